// File: rtl/ysyx_25040105_pkg.sv
// Shared types for the instruction-memory responder: FSM states, response
// error codes and the default reset-vector base address.
package ysyx_25040105_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    ERR_OK       = 2'd0,
    ERR_MISALIGN = 2'd1,
    ERR_RANGE    = 2'd2
  } rsp_err_e;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h8000_0000;

endpackage

// File: rtl/ysyx_25040105_imem_array.sv
// Word-organised instruction storage: one synchronous write port and one
// registered read port; a same-edge read of a word being written sees the old value.
module ysyx_25040105_imem_array #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEPTH_WORDS = 4096
) (
  input  logic                           clk,
  input  logic                           i_rst_n,
  input  logic                           i_rd_en,
  input  logic [$clog2(DEPTH_WORDS)-1:0] i_rd_idx,
  output logic [DATA_W-1:0]              o_rd_data,
  input  logic                           i_wr_en,
  input  logic [$clog2(DEPTH_WORDS)-1:0] i_wr_idx,
  input  logic [DATA_W-1:0]              i_wr_data
);

  logic [DATA_W-1:0] r_mem [DEPTH_WORDS];
  logic [DATA_W-1:0] r_rd_data;

  // Storage contents survive reset; only the read register is cleared.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_idx] <= i_wr_data;
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_idx];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/ysyx_25040105_imem_responder.sv
// Instruction-memory responder: accepts one fetch PC at a time, checks it,
// and returns the stored word LATENCY cycles after accept over valid/ready.
module ysyx_25040105_imem_responder
  import ysyx_25040105_pkg::*;
#(
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       DEPTH_WORDS = 4096,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(DEFAULT_BASE_ADDR),
  parameter int unsigned       LATENCY     = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [ADDR_W-1:0]              req_addr,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [DATA_W-1:0]              rsp_data,
  output logic [1:0]                     rsp_err,
  input  logic                           ld_en,
  input  logic [$clog2(DEPTH_WORDS)-1:0] ld_idx,
  input  logic [DATA_W-1:0]              ld_data
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W = 3;

  state_e            r_state;
  state_e            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_addr;
  rsp_err_e          r_err;
  logic [ADDR_W-1:0] w_word;
  logic              w_enter_resp;
  logic              w_ld_we;
  logic [DATA_W-1:0] w_rd_data;

  // Misalignment wins over range; any word offset with bits above the index
  // field set (including the wrap from addresses below the base) is out of range.
  function automatic rsp_err_e addr_check(input logic [1:0]        lsb,
                                          input logic [ADDR_W-1:0] word);
    if (lsb != 2'b00) return ERR_MISALIGN;
    if (|word[ADDR_W-1:IDX_W]) return ERR_RANGE;
    return ERR_OK;
  endfunction

  assign w_word       = (r_addr - BASE_ADDR) >> 2;
  assign w_enter_resp = (r_state == WAIT) && (r_cnt == '0);
  assign w_ld_we      = ld_en & rst;

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    unique case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_state_nxt = WAIT;
      end
      WAIT: begin
        if (r_cnt == '0) w_state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_err   <= ERR_OK;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE && req_valid) begin
        r_addr <= req_addr;
        r_cnt  <= CNT_W'(LATENCY - 1);
      end else if (r_state == WAIT && r_cnt != '0) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      // Error code and read data are captured together on entry to RESP and
      // then held until the IFU takes the response.
      if (w_enter_resp) begin
        r_err <= addr_check(r_addr[1:0], w_word);
      end
    end
  end

  ysyx_25040105_imem_array #(
    .DATA_W      (DATA_W),
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_array (
    .clk       (clk),
    .i_rst_n   (rst),
    .i_rd_en   (w_enter_resp),
    .i_rd_idx  (w_word[IDX_W-1:0]),
    .o_rd_data (w_rd_data),
    .i_wr_en   (w_ld_we),
    .i_wr_idx  (ld_idx),
    .i_wr_data (ld_data)
  );

  assign rsp_err  = r_err;
  assign rsp_data = (r_err == ERR_OK) ? w_rd_data : '0;

endmodule

// File: tb/tb_ysyx_25040105_imem_responder.sv
// Scoreboard bench for the instruction-memory responder, run on four
// instances with LATENCY 1..4 in parallel, each with its own driver and monitor.
module tb_ysyx_25040105_imem_responder;

  localparam int          LANES = 4;
  localparam int          DEPTH = 256;
  localparam int          IDX_W = $clog2(DEPTH);
  localparam logic [31:0] BASE  = 32'h8000_0000;

  logic clk = 1'b0;
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          snap;
    bit          seen;
    logic [31:0] data;
    logic [1:0]  err;
  } exp_t;

  task automatic chk(input string nm, input int lane, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s lane%0d @cyc%0d: got %h expected %h", nm, lane, cyc, act, exp);
    end
  endtask

  // Reference rules: low two bits must be zero, then the byte address must lie
  // in [BASE, BASE + 4*DEPTH).
  function automatic logic [1:0] exp_err(input logic [31:0] a);
    longint unsigned la = 64'(a);
    if (a[1:0] != 2'b00) return 2'd1;
    if (la < 64'(BASE) || la >= 64'(BASE) + 64'(4 * DEPTH)) return 2'd2;
    return 2'd0;
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'((a - BASE) / 4);
  endfunction

  function automatic int rand_idx();
    return ($urandom_range(0, 7) == 0) ? DEPTH - 1 : int'($urandom_range(0, 15));
  endfunction

  function automatic logic [31:0] rand_addr();
    int k = int'($urandom_range(0, 9));
    if (k <= 5) return BASE + 32'(4 * $urandom_range(0, 15));
    if (k == 6) return BASE + 32'(4 * (DEPTH - 1));
    if (k == 7) return BASE + 32'(4 * $urandom_range(0, 63)) + 32'($urandom_range(1, 3));
    if (k == 8) return BASE - 32'(4 * $urandom_range(1, 100));
    return ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC : BASE + 32'(4 * (DEPTH + $urandom_range(0, 100)));
  endfunction

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    localparam int L = g + 1;

    logic             rst, req_valid, req_ready, rsp_valid, rsp_ready, ld_en;
    logic [31:0]      req_addr, rsp_data, ld_data;
    logic [1:0]       rsp_err;
    logic [IDX_W-1:0] ld_idx;
    logic [31:0]      mdl [DEPTH];
    exp_t             q[$];
    int               acc_edge = 0;
    int               n_rsp = 0;
    bit               done = 1'b0;

    ysyx_25040105_imem_responder #(
      .ADDR_W      (32),
      .DATA_W      (32),
      .DEPTH_WORDS (DEPTH),
      .BASE_ADDR   (BASE),
      .LATENCY     (L)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_err   (rsp_err),
      .ld_en     (ld_en),
      .ld_idx    (ld_idx),
      .ld_data   (ld_data)
    );

    // Monitor: sees what the next rising edge will act on.
    always @(negedge clk) begin : mon
      exp_t e;
      if (!rst) begin
        q.delete();
        chk("rst_req_ready", g, 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", g, 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", g, rsp_data, 32'd0);
        chk("rst_rsp_err", g, 32'(rsp_err), 32'd0);
      end else begin
        chk("req_ready", g, 32'(req_ready), 32'(q.size() == 0));
        if (rsp_valid) begin
          if (q.size() == 0) begin
            chk("spurious_rsp", g, 32'(rsp_valid), 32'd0);
          end else begin
            if (!q[0].seen) begin
              chk("rsp_latency", g, 32'(cyc), 32'(q[0].due));
              q[0].seen = 1'b1;
            end
            chk("rsp_data", g, rsp_data, q[0].data);
            chk("rsp_err", g, 32'(rsp_err), 32'(q[0].err));
            if (rsp_ready) begin
              void'(q.pop_front());
              n_rsp++;
            end
          end
        end else if (q.size() != 0 && cyc >= q[0].due) begin
          chk("rsp_missing", g, 32'(rsp_valid), 32'd1);
          void'(q.pop_front());
        end
        if (req_valid && req_ready) begin
          e.addr = req_addr;
          e.due  = cyc + 1 + L;
          e.snap = 1'b0;
          e.seen = 1'b0;
          e.data = 32'd0;
          e.err  = 2'd0;
          q.push_back(e);
        end
        // The word is sampled from the model as it stands just before the
        // edge that raises rsp_valid; a write on that edge is not yet visible.
        if (q.size() != 0 && !q[0].snap && cyc == q[0].due - 1) begin
          q[0].snap = 1'b1;
          q[0].err  = exp_err(q[0].addr);
          q[0].data = (q[0].err == 2'd0) ? mdl[word_of(q[0].addr)] : 32'd0;
        end
        if (ld_en) mdl[ld_idx] = ld_data;
      end
    end

    task automatic tick();
      @(posedge clk);
      #1;
    endtask

    task automatic load(input int idx, input logic [31:0] d);
      ld_en   = 1'b1;
      ld_idx  = IDX_W'(idx);
      ld_data = d;
      tick();
      ld_en = 1'b0;
    endtask

    task automatic issue(input logic [31:0] a, input bit hold);
      int n = 0;
      bit ok = 1'b0;
      req_valid = 1'b1;
      req_addr  = a;
      do begin
        ok = req_ready;
        tick();
        n++;
      end while (!ok && n < 200);
      if (!ok) chk("accept_timeout", g, 32'(ok), 32'd1);
      acc_edge = cyc;
      if (!hold) req_valid = 1'b0;
    endtask

    task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 200) begin
        tick();
        n++;
      end
      chk("drain", g, 32'(q.size()), 32'd0);
    endtask

    initial begin : drv
      int prev;
      int rsp0;
      bit took;
      rst = 1'b0; req_valid = 1'b0; req_addr = 32'd0; rsp_ready = 1'b1;
      ld_en = 1'b0; ld_idx = '0; ld_data = 32'd0;
      repeat (3) tick();
      rst = 1'b1;
      load(0, 32'h0010_0073);
      load(1, 32'h0000_0413);
      for (int i = 2; i < 16; i++) load(i, $urandom);
      load(DEPTH - 1, $urandom);

      // Basic fetch with the IFU always ready.
      rsp_ready = 1'b1;
      issue(BASE, 1'b0);
      drain();

      // IFU stalls the response for three cycles.
      rsp_ready = 1'b0;
      issue(BASE + 32'd4, 1'b0);
      for (int n = 0; n < 50 && !rsp_valid; n++) tick();
      chk("stall_valid", g, 32'(rsp_valid), 32'd1);
      repeat (3) tick();
      rsp_ready = 1'b1;
      drain();

      // Misaligned, below base, one past the last word.
      issue(BASE + 32'd2, 1'b0);                   drain();
      issue(BASE - 32'd4, 1'b0);                   drain();
      issue(BASE + 32'(4 * DEPTH), 1'b0);          drain();

      // Loader write lands on the same edge the read happens.
      issue(BASE, 1'b0);
      repeat (L - 1) tick();
      load(0, 32'hDEAD_BEEF);
      drain();
      issue(BASE, 1'b0);
      drain();

      // Reset while waiting; loader activity during reset must be dropped.
      issue(BASE + 32'd4, 1'b0);
      rst = 1'b0;
      ld_en = 1'b1; ld_idx = IDX_W'(1); ld_data = 32'h0BAD_0BAD;
      repeat (2) tick();
      ld_en = 1'b0;
      rst = 1'b1;
      repeat (L + 3) tick();
      issue(BASE + 32'd4, 1'b0);
      drain();

      // Back-to-back requests with req_valid held high.
      prev = 0;
      rsp0 = n_rsp;
      for (int i = 0; i < 8; i++) begin
        issue(BASE + 32'(4 * i), 1'b1);
        if (i > 0) chk("b2b_interval", g, 32'(acc_edge - prev), 32'(L + 2));
        prev = acc_edge;
      end
      req_valid = 1'b0;
      drain();
      chk("b2b_count", g, 32'(n_rsp - rsp0), 32'd8);

      // Random traffic: stalls, gaps, loader writes at any time.
      for (int c = 0; c < 400; c++) begin
        rsp_ready = ($urandom_range(0, 3) != 0);
        ld_en     = ($urandom_range(0, 7) == 0);
        ld_idx    = IDX_W'(rand_idx());
        ld_data   = $urandom;
        if (!req_valid && $urandom_range(0, 2) == 0) begin
          req_valid = 1'b1;
          req_addr  = rand_addr();
        end
        took = req_valid && req_ready;
        tick();
        if (took) req_valid = 1'b0;
      end
      req_valid = 1'b0;
      ld_en     = 1'b0;
      rsp_ready = 1'b1;
      drain();
      done = 1'b1;
    end
  end

  initial begin : main
    int  n = 0;
    bit  all_done = 1'b0;
    while (!all_done && n < 20000) begin
      @(posedge clk);
      n++;
      all_done = g_lane[0].done && g_lane[1].done && g_lane[2].done && g_lane[3].done;
    end
    chk("lanes_done", -1, 32'(all_done), 32'd1);
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
